breath_ctrl: RTL and testbench
==============================

# breath_ctrl

Upstream control stage for the breathing-light PWM. Generates the µs/ms timebase, debounces a push-button that cycles the lighting mode (off / 1 s breath / 2 s breath / on), and emits a per-millisecond duty value plus the in-period PWM position. The downstream PWM stage needs only one comparison, `led = (pwm_pos < duty)`, and owns no counters.

## Interface
- `CLK_PER_US`, default 50: clk cycles per µs tick (50 MHz).
- `US_PER_MS`, default 1000: µs per PWM period; also the number of ramp steps. Must be ≤ 1023.
- `DEBOUNCE_MS`, default 20: ms the key level must hold before acceptance.
- `clk`  in  1  system clock; sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `key_in`  in  1  raw button; active-low (0 = pressed); asynchronous to `clk`.
- `tick_us`  out  1  one-cycle pulse at the end of each µs.
- `tick_ms`  out  1  one-cycle pulse at the end of each PWM period.
- `pwm_pos`  out  10  µs index within the current period, 0..US_PER_MS-1.
- `duty`  out  10  on-time for the current period, in µs, 0..US_PER_MS.
- `mode`  out  2  0 OFF, 1 BREATH1, 2 BREATH2, 3 ON.
- `key_pulse`  out  1  one-cycle pulse per accepted press.

## Operation
- Timebase:
  - `cnt_us` counts 0..CLK_PER_US-1 and wraps. `tick_us` = (cnt_us == max).
  - `pwm_pos` advances on `tick_us` and wraps at US_PER_MS-1. `tick_ms` = tick_us && pwm_pos == max.
  - Both counters free-run and are never cleared except by `rst`.
- Key path:
  - Two-flop synchronizer, reset value 1.
  - `key_filter` holds a stable level (reset 1). While the synchronized level differs from the stable level, it counts `tick_ms` events. Equality at any time clears the count.
  - When the count reaches DEBOUNCE_MS, the stable level takes the new value.
  - A stable 1→0 transition raises `key_pulse` for one cycle. Release produces no pulse.
- Mode FSM: on `key_pulse`, mode advances OFF→BREATH1→BREATH2→ON→OFF.
- Ramp:
  - `step_cnt` runs 0..US_PER_MS-1. `phase` is 0 (brightening) or 1 (dimming).
  - `div2` is a toggle flag for BREATH2.
  - Step enable:
    - BREATH1: every `tick_ms`.
    - BREATH2: every `tick_ms` when div2 == 1; div2 toggles on each `tick_ms`.
  - On step: step_cnt increments. At US_PER_MS-1 it wraps to 0 and phase toggles.
  - Result: a 1 s ramp in BREATH1 and a 2 s ramp in BREATH2.
  - OFF and ON hold step_cnt, phase and div2 at 0.
- Duty (registered):
  - OFF: 0.
  - ON: US_PER_MS.
  - BREATH, phase 0: step_cnt.
  - BREATH, phase 1: US_PER_MS-1-step_cnt.
- All arithmetic is unsigned and uses fixed widths. Comparisons use width-matched constants.

## Timing
- Reset values: all counters 0, `tick_us`/`tick_ms`/`key_pulse` 0, `pwm_pos` 0, `duty` 0, `mode` OFF, phase 0, div2 0, stable key 1.
- `rst` mid-operation: every register returns to its reset value on the next edge. A press already in debounce is discarded.
- `tick_us` and `tick_ms` are combinational from the counters. They are high in the cycle before the counters wrap.
- Key latency:
  - Synchronizer: 2 cycles.
  - Debounce: the DEBOUNCE_MS-th `tick_ms` after the level is seen.
  - `key_pulse` asserts in the cycle after the stable level updates.
  - `mode` updates 1 cycle after `key_pulse`.
  - `duty` reflects the new mode 1 cycle after `mode`.
- Mode change: the cycle `mode` updates, step_cnt, phase and div2 clear to 0. If `key_pulse` and a step enable coincide, the mode change wins and the step is dropped.
- `duty` lags step_cnt/phase by exactly 1 cycle. A step occurs on `tick_ms`, so `duty` is stable for the whole of each following period, `pwm_pos` 0..max.
- Boundaries:
  - Phase-0 wrap: duty goes 999 → 999 (first dimming value).
  - Phase-1 wrap: duty goes 0 → 0.
  - No glitch to 0 or US_PER_MS at the turnarounds.

## Structure
- Shared package `breath_pkg`: mode encoding constants (OFF/BREATH1/BREATH2/ON) and the 10-bit duty/position width constant. The downstream PWM stage imports the same package.
- One sub-module, `key_filter`: synchronizer, debounce counter and press-pulse generation. Ports: clk, rst, key_in, tick_ms, key_pulse.
- The timebase, mode FSM and ramp stay in `breath_ctrl`.

## Test plan
All scenarios use CLK_PER_US=2, US_PER_MS=4, DEBOUNCE_MS=2.
1. Reset, then free-run → `tick_us` every 2 cycles, `tick_ms` every 8 cycles, `pwm_pos` 0,1,2,3,0; `duty`=0, `mode`=0.
2. Hold `key_in`=0 for 3 ms → exactly one `key_pulse`, `mode`=1. Then observe `duty` per period: 0,1,2,3,3,2,1,0,0,1…
3. Glitch `key_in` low for 1.5 ms, then high → no `key_pulse`, mode unchanged. Bounce 0/1 every cycle for 1 ms, then hold 0 → single pulse.
4. Four clean presses → mode 1,2,3,0. In mode 2, `duty` changes every 2nd `tick_ms` (0,0,1,1,2…). Mode 3 gives `duty`=4; mode 0 gives `duty`=0.
5. Press accepted on the same cycle as a step in mode 1, with step_cnt=2 → step dropped; mode 2 starts with step_cnt 0 and `duty` 0.
6. Assert `rst` for 1 cycle mid-ramp (mode 2, phase 1) → next cycle all outputs are at reset values: mode 0, `duty` 0, `pwm_pos` 0.

Source files
------------

// File: rtl/breath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : breath_pkg
//  Description : Shared definitions for the breathing-light control and PWM
//                stages: mode encoding, duty/position width, mode sequencing.
//  Revision    : 1.0 - initial release
// ============================================================================
package breath_pkg;

    // Width of duty and in-period position values (covers 0..1023).
    localparam int c_DUTY_W = 10;

    typedef logic [c_DUTY_W-1:0] duty_t;

    // Lighting mode encoding, shared with the downstream PWM stage.
    localparam logic [1:0] c_MODE_OFF     = 2'd0;
    localparam logic [1:0] c_MODE_BREATH1 = 2'd1;
    localparam logic [1:0] c_MODE_BREATH2 = 2'd2;
    localparam logic [1:0] c_MODE_ON      = 2'd3;

    // Button cycles OFF -> BREATH1 -> BREATH2 -> ON -> OFF.
    function automatic logic [1:0] next_mode(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            c_MODE_OFF:     nxt = c_MODE_BREATH1;
            c_MODE_BREATH1: nxt = c_MODE_BREATH2;
            c_MODE_BREATH2: nxt = c_MODE_ON;
            default:        nxt = c_MODE_OFF;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/breath_ctrl_key_filter.sv
`default_nettype none
// ============================================================================
//  Module      : key_filter
//  Description : Push-button conditioning: two-flop synchronizer, debounce
//                counter clocked by the millisecond tick, and a one-cycle
//                pulse on each accepted press (stable 1 -> 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module key_filter #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    input  logic tick_ms,
    output logic key_pulse
);

    // The counter only needs to reach DEBOUNCE_MS-1; acceptance happens on
    // the tick that would take it to DEBOUNCE_MS.
    localparam int                 c_CNT_W    = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_key_pulse;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_differ;
    logic               w_accept;

    // New level is accepted on the DEBOUNCE_MS-th tick_ms it has persisted.
    assign w_differ = (r_sync2 != r_stable);
    assign w_accept = w_differ && tick_ms && (r_cnt == c_CNT_LAST);

    // Two-flop synchronizer; idles high because the button is active-low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count ms ticks while the level differs, clear on any match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else if (!w_differ) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
        end else if (tick_ms) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Press pulse is high in the first cycle the stable level reads 0;
    // releases are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_pulse <= 1'b0;
        end else begin
            r_key_pulse <= w_accept && !r_sync2;
        end
    end

    assign key_pulse = r_key_pulse;

endmodule
`default_nettype wire

// File: rtl/breath_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : breath_ctrl
//  Description : Breathing-light control stage. Generates the us/ms timebase,
//                cycles the lighting mode from a debounced button, and
//                produces a per-period duty value plus the in-period PWM
//                position so the PWM stage only needs led = pwm_pos < duty.
//  Revision    : 1.0 - initial release
// ============================================================================
module breath_ctrl
    import breath_pkg::*;
#(
    parameter int CLK_PER_US  = 50,
    parameter int US_PER_MS   = 1000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_in,
    output logic                tick_us,
    output logic                tick_ms,
    output logic [c_DUTY_W-1:0] pwm_pos,
    output logic [c_DUTY_W-1:0] duty,
    output logic [1:0]          mode,
    output logic                key_pulse
);

    localparam int                c_US_W      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [c_US_W-1:0] c_US_LAST   = c_US_W'(CLK_PER_US - 1);
    localparam logic [c_US_W-1:0] c_US_ONE    = c_US_W'(1);
    localparam duty_t             c_POS_LAST  = c_DUTY_W'(US_PER_MS - 1);
    localparam duty_t             c_DUTY_FULL = c_DUTY_W'(US_PER_MS);
    localparam duty_t             c_DUTY_ONE  = c_DUTY_W'(1);

    logic [c_US_W-1:0] r_cnt_us;
    duty_t             r_pwm_pos;
    logic [1:0]        r_mode;
    duty_t             r_step_cnt;
    logic              r_phase;
    logic              r_div2;
    duty_t             r_duty;

    logic              w_tick_us;
    logic              w_tick_ms;
    logic              w_key_pulse;
    logic              w_is_breath1;
    logic              w_is_breath2;
    logic              w_step_en;

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    assign w_tick_us = (r_cnt_us == c_US_LAST);
    assign w_tick_ms = w_tick_us && (r_pwm_pos == c_POS_LAST);

    // Free-running clock-cycle counter within one microsecond.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_us <= '0;
        end else if (w_tick_us) begin
            r_cnt_us <= '0;
        end else begin
            r_cnt_us <= r_cnt_us + c_US_ONE;
        end
    end

    // Microsecond position within the PWM period; one period per ms tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_pos <= '0;
        end else if (w_tick_us) begin
            if (r_pwm_pos == c_POS_LAST) begin
                r_pwm_pos <= '0;
            end else begin
                r_pwm_pos <= r_pwm_pos + c_DUTY_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    key_filter #(
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_key_filter (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .tick_ms   (w_tick_ms),
        .key_pulse (w_key_pulse)
    );

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    // Each accepted press advances the mode one position around the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= c_MODE_OFF;
        end else if (w_key_pulse) begin
            r_mode <= next_mode(r_mode);
        end
    end

    // ------------------------------------------------------------------
    // Ramp
    // ------------------------------------------------------------------
    assign w_is_breath1 = (r_mode == c_MODE_BREATH1);
    assign w_is_breath2 = (r_mode == c_MODE_BREATH2);
    assign w_step_en    = w_tick_ms && (w_is_breath1 || (w_is_breath2 && r_div2));

    // Triangle ramp: step_cnt sweeps the period length, phase selects the
    // brightening or dimming half. A mode change restarts the ramp from the
    // dark end; acceptance lands on a ms tick, so the clear here also
    // discards the step taken on that tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_cnt <= '0;
            r_phase    <= 1'b0;
            r_div2     <= 1'b0;
        end else if (w_key_pulse || !(w_is_breath1 || w_is_breath2)) begin
            r_step_cnt <= '0;
            r_phase    <= 1'b0;
            r_div2     <= 1'b0;
        end else begin
            if (w_is_breath2 && w_tick_ms) begin
                r_div2 <= ~r_div2;
            end
            if (w_step_en) begin
                if (r_step_cnt == c_POS_LAST) begin
                    r_step_cnt <= '0;
                    r_phase    <= ~r_phase;
                end else begin
                    r_step_cnt <= r_step_cnt + c_DUTY_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Duty
    // ------------------------------------------------------------------
    // Registered duty; the dimming half mirrors step_cnt so both turnarounds
    // repeat the end value instead of jumping to 0 or full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= '0;
        end else begin
            case (r_mode)
                c_MODE_OFF: r_duty <= '0;
                c_MODE_ON:  r_duty <= c_DUTY_FULL;
                default:    r_duty <= r_phase ? (c_POS_LAST - r_step_cnt) : r_step_cnt;
            endcase
        end
    end

    assign tick_us   = w_tick_us;
    assign tick_ms   = w_tick_ms;
    assign pwm_pos   = r_pwm_pos;
    assign duty      = r_duty;
    assign mode      = r_mode;
    assign key_pulse = w_key_pulse;

endmodule
`default_nettype wire

// File: tb/tb_breath_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_breath_ctrl
//  Description : Directed self-checking bench for breath_ctrl with
//                CLK_PER_US=2, US_PER_MS=4, DEBOUNCE_MS=2 (8-cycle period).
//                cyc counts clock edges since the last reset release, so
//                the sample taken at the falling edge with cyc == n sees the
//                n-th cycle after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_breath_ctrl;

    localparam int c_CLK_PER_US  = 2;
    localparam int c_US_PER_MS   = 4;
    localparam int c_DEBOUNCE_MS = 2;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       key_in = 1'b1;
    logic       tick_us;
    logic       tick_ms;
    logic [9:0] pwm_pos;
    logic [9:0] duty;
    logic [1:0] mode;
    logic       key_pulse;

    int cyc        = 0;
    int pulse_cnt  = 0;
    int last_pulse = -1;
    int errors     = 0;
    int checks     = 0;

    int exp_duty_b1 [10] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
    int exp_duty_b2 [9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 3};

    breath_ctrl #(
        .CLK_PER_US  (c_CLK_PER_US),
        .US_PER_MS   (c_US_PER_MS),
        .DEBOUNCE_MS (c_DEBOUNCE_MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .tick_us   (tick_us),
        .tick_ms   (tick_ms),
        .pwm_pos   (pwm_pos),
        .duty      (duty),
        .mode      (mode),
        .key_pulse (key_pulse)
    );

    initial forever #5 clk = ~clk;

    // Cycle counter and key_pulse monitor.
    always @(posedge clk) begin
        if (rst) begin
            cyc <= 0;
        end else begin
            if (key_pulse === 1'b1) begin
                pulse_cnt  <= pulse_cnt + 1;
                last_pulse <= cyc;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        // ---------------- 1: reset and free-running timebase ----------------
        repeat (3) @(negedge clk);
        check("rst_tick_us",   tick_us,   0);
        check("rst_tick_ms",   tick_ms,   0);
        check("rst_pwm_pos",   pwm_pos,   0);
        check("rst_duty",      duty,      0);
        check("rst_mode",      mode,      0);
        check("rst_key_pulse", key_pulse, 0);
        rst = 1'b0;
        for (int n = 0; n < 16; n++) begin
            wait_until(n);
            check("t1_tick_us",  tick_us, (n % 2) == 1);
            check("t1_tick_ms",  tick_ms, (n % 8) == 7);
            check("t1_pwm_pos",  pwm_pos, (n / 2) % 4);
        end
        check("t1_duty", duty, 0);
        check("t1_mode", mode, 0);

        // ---------------- 2: clean press, BREATH1 ramp ----------------
        wait_until(16); key_in = 1'b0;
        wait_until(31);
        check("t2_no_early_pulse", pulse_cnt, 0);
        check("t2_mode_before",    mode,      0);
        wait_until(32);
        check("t2_key_pulse",      key_pulse, 1);
        check("t2_mode_at_pulse",  mode,      0);
        wait_until(33);
        check("t2_mode_after",     mode,      1);
        check("t2_pulse_cleared",  key_pulse, 0);
        wait_until(39);
        check("t2_duty0", duty, exp_duty_b1[0]);
        wait_until(40); key_in = 1'b1;
        for (int i = 1; i < 10; i++) begin
            wait_until(39 + 8 * i);
            check("t2_duty", duty, exp_duty_b1[i]);
        end
        check("t2_pulse_count", pulse_cnt,  1);
        check("t2_pulse_cycle", last_pulse, 32);

        // ---------------- 3: glitch rejected, bounce then hold ----------------
        wait_until(112); key_in = 1'b0;
        wait_until(124); key_in = 1'b1;
        wait_until(140);
        check("t3_glitch_no_pulse", pulse_cnt, 1);
        check("t3_glitch_mode",     mode,      1);
        for (int i = 0; i < 8; i++) begin
            wait_until(144 + i);
            key_in = (i % 2 == 1);
        end
        wait_until(152); key_in = 1'b0;
        wait_until(167);
        check("t3_bounce_no_early", pulse_cnt, 1);
        wait_until(168);
        check("t3_bounce_pulse",    key_pulse, 1);
        wait_until(169);
        check("t3_bounce_count",    pulse_cnt,  2);
        check("t3_bounce_cycle",    last_pulse, 168);
        check("t3_bounce_mode",     mode,       2);

        // ---------------- 4: BREATH2 pace, ON, OFF, back to BREATH1 ----------------
        wait_until(175);
        check("t4_b2_duty_a", duty, 0);
        wait_until(176); key_in = 1'b1;
        wait_until(183); check("t4_b2_duty_b", duty, 0);
        wait_until(191); check("t4_b2_duty_c", duty, 1);
        wait_until(199); check("t4_b2_duty_d", duty, 1);
        wait_until(207); check("t4_b2_duty_e", duty, 2);
        wait_until(208); key_in = 1'b0;
        wait_until(224); check("t4_on_pulse", key_pulse, 1);
        wait_until(226);
        check("t4_on_mode", mode, 3);
        check("t4_on_duty", duty, 4);
        wait_until(232); key_in = 1'b1;
        wait_until(248); key_in = 1'b0;
        wait_until(263); check("t4_on_duty_hold", duty, 4);
        wait_until(266);
        check("t4_off_mode", mode, 0);
        check("t4_off_duty", duty, 0);
        wait_until(272); key_in = 1'b1;
        wait_until(288); key_in = 1'b0;
        wait_until(305); check("t4_b1_mode", mode, 1);
        wait_until(312); key_in = 1'b1;

        // ---------------- 5: press accepted on a step tick (step_cnt=2) ----------------
        wait_until(344); key_in = 1'b0;
        wait_until(359);
        check("t5_mode_before", mode, 1);
        check("t5_duty_step2",  duty, 1);
        wait_until(360); check("t5_pulse", key_pulse, 1);
        wait_until(361); check("t5_mode",  mode,      2);
        wait_until(362); check("t5_duty_restart", duty, 0);
        wait_until(367); check("t5_b2_duty", duty, exp_duty_b2[0]);
        wait_until(368); key_in = 1'b1;
        for (int i = 1; i < 9; i++) begin
            wait_until(367 + 8 * i);
            check("t5_b2_duty", duty, exp_duty_b2[i]);
            if (i == 7) key_in = 1'b0;   // press begins at cycle 423, dropped by reset
        end
        check("t5_pulse_count", pulse_cnt, 6);

        // ---------------- 6: reset mid-ramp (BREATH2, dimming) ----------------
        wait_until(436); rst = 1'b1;
        @(negedge clk);
        check("t6_mode",      mode,      0);
        check("t6_duty",      duty,      0);
        check("t6_pwm_pos",   pwm_pos,   0);
        check("t6_tick_us",   tick_us,   0);
        check("t6_tick_ms",   tick_ms,   0);
        check("t6_key_pulse", key_pulse, 0);
        rst = 1'b0;
        wait_until(1);  check("t6_tick_us_run", tick_us, 1);
        wait_until(3);  check("t6_pwm_pos_run", pwm_pos, 1);
        wait_until(12);
        check("t6_press_discarded", pulse_cnt, 6);
        check("t6_mode_hold",       mode,      0);
        wait_until(16); check("t6_fresh_pulse", key_pulse, 1);
        wait_until(17); check("t6_fresh_mode",  mode,      1);
        key_in = 1'b1;
        wait_until(24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
